// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Shares one 16-bit ripple_adder (carry-in 0) between two requesters.
//   A round-robin grant picks a requester in IDLE. Its operands are latched
//   and held on the adder for ADD_CYCLES cycles, because the ripple chain is a
//   multicycle path. Sum/CO are then registered and offered on a single
//   response port with backpressure.
//
// Parameters
//   ADD_CYCLES   cycles operands are held on the adder before capture (1..8)
//
// Ports
//   Clk          clock, all state updates on the rising edge
//   Reset_n      asynchronous active-low reset
//   ReqN_Valid   requester N has an operation (N = 0, 1)
//   ReqN_A/B     requester N operands, sampled only in the handshake cycle
//   ReqN_Ready   requester N accepted this cycle (combinational from Valid)
//   Resp_Valid   result available (registered)
//   Resp_Ready   consumer takes the result
//   Resp_Id      requester that issued the result
//   Resp_Sum     A+B mod 2^16
//   Resp_CO      carry out of bit 15
//   Busy         high whenever the block is not idle (registered)
// -----------------------------------------------------------------------------

// Plain ripple-carry adder; the carry chain is treated as a multicycle path.
//   a, b  operands      ci  carry in
//   sum   a+b+ci        co  carry out of the top bit
module ripple_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[WIDTH];

endmodule

module adder_arbiter #(
  parameter int unsigned ADD_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req0_Valid,
  input  logic [15:0] Req0_A,
  input  logic [15:0] Req0_B,
  output logic        Req0_Ready,
  input  logic        Req1_Valid,
  input  logic [15:0] Req1_A,
  input  logic [15:0] Req1_B,
  output logic        Req1_Ready,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic        Resp_Id,
  output logic [15:0] Resp_Sum,
  output logic        Resp_CO,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(ADD_CYCLES - 1);

  state_t      state;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [2:0]  cnt;
  logic        prio;
  logic [15:0] sum_reg;
  logic        co_reg;
  logic        id_reg;

  logic [15:0] add_sum;
  logic        add_co;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        winner;

  // The adder only ever sees the latched operands, so its inputs are stable
  // for the whole ADD phase regardless of what the requesters drive.
  ripple_adder #(
    .WIDTH (16)
  ) u_adder (
    .a   (a_reg),
    .b   (b_reg),
    .ci  (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

  // A lone requester always wins; on contention prio names the winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = Req0_Valid & (~Req1_Valid | ~prio);
      grant1 = Req1_Valid & (~Req0_Valid |  prio);
    end
  end

  assign Req0_Ready = grant0;
  assign Req1_Ready = grant1;
  assign accept     = grant0 | grant1;
  assign winner     = grant1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      prio    <= 1'b0;
      sum_reg <= '0;
      co_reg  <= 1'b0;
      id_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= winner ? Req1_A : Req0_A;
            b_reg  <= winner ? Req1_B : Req0_B;
            id_reg <= winner;
            prio   <= ~winner;
            cnt    <= CNT_LOAD;
            state  <= ADD;
          end
        end
        ADD: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            sum_reg <= add_sum;
            co_reg  <= add_co;
            state   <= RESP;
          end
        end
        RESP: begin
          if (Resp_Ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Resp_Valid = (state == RESP);
  assign Busy       = (state != IDLE);
  assign Resp_Id    = id_reg;
  assign Resp_Sum   = sum_reg;
  assign Resp_CO    = co_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Self-checking bench for adder_arbiter. Two instances are exercised:
//   index 0 with ADD_CYCLES=1 and index 1 with ADD_CYCLES=4. Directed scenario
//   tasks are followed by randomized traffic checked against a transaction-
//   level model (handshake timestamps, last winner, A+B computed with a 17-bit
//   add).
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;

  logic        v0 [2];
  logic        v1 [2];
  logic        rr [2];
  logic [15:0] a0 [2];
  logic [15:0] b0 [2];
  logic [15:0] a1 [2];
  logic [15:0] b1 [2];

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv   [2];
  logic        rid  [2];
  logic        rco  [2];
  logic        busy [2];
  logic [15:0] rsum [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  adder_arbiter #(.ADD_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0_Valid(v0[0]), .Req0_A(a0[0]), .Req0_B(b0[0]), .Req0_Ready(rdy0[0]),
    .Req1_Valid(v1[0]), .Req1_A(a1[0]), .Req1_B(b1[0]), .Req1_Ready(rdy1[0]),
    .Resp_Valid(rv[0]), .Resp_Ready(rr[0]), .Resp_Id(rid[0]),
    .Resp_Sum(rsum[0]), .Resp_CO(rco[0]), .Busy(busy[0])
  );

  adder_arbiter #(.ADD_CYCLES(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0_Valid(v0[1]), .Req0_A(a0[1]), .Req0_B(b0[1]), .Req0_Ready(rdy0[1]),
    .Req1_Valid(v1[1]), .Req1_A(a1[1]), .Req1_B(b1[1]), .Req1_Ready(rdy1[1]),
    .Resp_Valid(rv[1]), .Resp_Ready(rr[1]), .Resp_Id(rid[1]),
    .Resp_Sum(rsum[1]), .Resp_CO(rco[1]), .Busy(busy[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      v0[d] = 1'b0; v1[d] = 1'b0; rr[d] = 1'b1;
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
    end
  endtask

  // Leaves the bench 1 ns after a rising edge with both DUTs idle.
  task automatic apply_reset();
    @(posedge Clk); #1;
    idle_inputs();
    Reset_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  // Waits (bounded) for ReqN_Ready at a falling edge; t is that cycle.
  // Returns 1 ns after the following rising edge.
  task automatic wait_ready(input int d, input int r, input bit drop, output int t);
    bit seen;
    seen = 1'b0;
    t = -1;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge Clk);
      if (((r == 0) ? rdy0[d] : rdy1[d]) === 1'b1) begin
        seen = 1'b1;
        t = cyc;
      end
      @(posedge Clk); #1;
    end
    if (seen && drop) begin
      if (r == 0) v0[d] = 1'b0;
      else        v1[d] = 1'b0;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL ready_timeout d=%0d req=%0d: Ready got 0 for 60 cycles, required 1", d, r);
    end
  endtask

  // Waits (bounded) for Resp_Valid; returns at the falling edge where it is high.
  task automatic wait_resp(input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (rv[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge Clk); #1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL resp_timeout d=%0d: Resp_Valid got 0 for 60 cycles, required 1", d);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #3 Reset_n = 1'b0;
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({rdy0[d], rdy1[d], rv[d], rid[d], rsum[d], rco[d], busy[d]} !== 22'd0) begin
        n_bad++;
        $display("FAIL reset_outputs d=%0d: got %h required 000000", d,
                 {rdy0[d], rdy1[d], rv[d], rid[d], rsum[d], rco[d], busy[d]});
      end
    end
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    int t;
    rr[0] = 1'b1;
    a0[0] = 16'h1234; b0[0] = 16'h0001; v0[0] = 1'b1;
    wait_ready(0, 0, 1'b1, t);
    @(negedge Clk);
    n_cmp++;
    if ({busy[0], rv[0]} !== 2'b10) begin
      n_bad++;
      $display("FAIL basic_T+1 busy,valid: got %b required 10", {busy[0], rv[0]});
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    n_cmp++;
    if ({busy[0], rv[0], rid[0], rsum[0], rco[0]} !== {1'b1, 1'b1, 1'b0, 16'h1235, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_T+2 busy,valid,id,sum,co: got %h required %h",
               {busy[0], rv[0], rid[0], rsum[0], rco[0]}, {1'b1, 1'b1, 1'b0, 16'h1235, 1'b0});
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_T+3 busy: got %b required 0", busy[0]);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_carry();
    logic [15:0] va [2];
    logic [15:0] vb [2];
    int t;
    bit ok;
    va[0] = 16'hFFFF; vb[0] = 16'h0001;
    va[1] = 16'h8000; vb[1] = 16'h8000;
    rr[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a1[0] = va[i]; b1[0] = vb[i]; v1[0] = 1'b1;
      wait_ready(0, 1, 1'b1, t);
      wait_resp(0, ok);
      if (ok) begin
        n_cmp++;
        if ({rid[0], rsum[0], rco[0]} !== {1'b1, 16'h0000, 1'b1}) begin
          n_bad++;
          $display("FAIL carry_%0d id,sum,co: got %h required %h", i,
                   {rid[0], rsum[0], rco[0]}, {1'b1, 16'h0000, 1'b1});
        end
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_round_robin();
    int got;
    int both;
    logic        eid;
    logic [15:0] es;
    apply_reset();
    got = 0;
    both = 0;
    a0[0] = 16'd1; b0[0] = 16'd1; a1[0] = 16'd2; b1[0] = 16'd2;
    v0[0] = 1'b1; v1[0] = 1'b1; rr[0] = 1'b1;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge Clk);
      if (rdy0[0] === 1'b1 && rdy1[0] === 1'b1) both++;
      if (rv[0] === 1'b1) begin
        eid = got[0];
        es  = eid ? 16'h0004 : 16'h0002;
        n_cmp++;
        if ({rid[0], rsum[0]} !== {eid, es}) begin
          n_bad++;
          $display("FAIL rr_resp_%0d id,sum: got %h required %h", got, {rid[0], rsum[0]}, {eid, es});
        end
        got++;
      end
      @(posedge Clk); #1;
    end
    n_cmp++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL rr_count: got %0d responses required 4", got);
    end
    n_cmp++;
    if (both != 0) begin
      n_bad++;
      $display("FAIL rr_dual_ready: got %0d cycles with both Ready required 0", both);
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
  endtask

  task automatic test_backpressure();
    int t;
    bit ok;
    logic [16:0] e;
    v1[0] = 1'b0;
    a0[0] = 16'($urandom); b0[0] = 16'($urandom);
    e = {1'b0, a0[0]} + {1'b0, b0[0]};
    rr[0] = 1'b0; v0[0] = 1'b1;
    wait_ready(0, 0, 1'b0, t);
    wait_resp(0, ok);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(posedge Clk); #1;
        @(negedge Clk);
      end
      n_cmp++;
      if ({rv[0], rid[0], rsum[0], rco[0], rdy0[0], rdy1[0]} !== {1'b1, 1'b0, e[15:0], e[16], 2'b00}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d valid,id,sum,co,rdy0,rdy1: got %h required %h", k,
                 {rv[0], rid[0], rsum[0], rco[0], rdy0[0], rdy1[0]},
                 {1'b1, 1'b0, e[15:0], e[16], 2'b00});
      end
    end
    @(posedge Clk); #1;
    rr[0] = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({rv[0], rdy0[0]} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release valid,rdy0: got %b required 10", {rv[0], rdy0[0]});
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    n_cmp++;
    if ({busy[0], rdy0[0]} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_accept busy,rdy0: got %b required 01", {busy[0], rdy0[0]});
    end
    @(posedge Clk); #1;
    v0[0] = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
  endtask

  task automatic test_multicycle();
    int t;
    rr[1] = 1'b1;
    a0[1] = 16'h00FF; b0[1] = 16'h0F01; v0[1] = 1'b1;
    wait_ready(1, 0, 1'b1, t);
    for (int k = 1; k <= 5; k++) begin
      a0[1] = 16'($urandom); b0[1] = 16'($urandom);
      @(negedge Clk);
      if (k < 5) begin
        n_cmp++;
        if ({busy[1], rv[1], dut4.a_reg, dut4.b_reg} !== {1'b1, 1'b0, 16'h00FF, 16'h0F01}) begin
          n_bad++;
          $display("FAIL mc_hold_T+%0d busy,valid,a_reg,b_reg: got %h required %h", k,
                   {busy[1], rv[1], dut4.a_reg, dut4.b_reg}, {1'b1, 1'b0, 16'h00FF, 16'h0F01});
        end
      end else begin
        n_cmp++;
        if ({rv[1], rsum[1], rco[1]} !== {1'b1, 16'h1000, 1'b0}) begin
          n_bad++;
          $display("FAIL mc_result_T+5 valid,sum,co: got %h required %h",
                   {rv[1], rsum[1], rco[1]}, {1'b1, 16'h1000, 1'b0});
        end
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int seen_rv;
    rr[0] = 1'b1;
    a0[0] = 16'($urandom); b0[0] = 16'($urandom); v0[0] = 1'b1;
    wait_ready(0, 0, 1'b1, t);
    #2 Reset_n = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({rv[0], busy[0]} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_async valid,busy: got %b required 00", {rv[0], busy[0]});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    n_cmp++;
    if ({rdy0[0], rdy1[0], rv[0], rid[0], rsum[0], rco[0], busy[0]} !== 22'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h required 000000",
               {rdy0[0], rdy1[0], rv[0], rid[0], rsum[0], rco[0], busy[0]});
    end
    seen_rv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (rv[0] !== 1'b0) seen_rv++;
    end
    n_cmp++;
    if (seen_rv != 0) begin
      n_bad++;
      $display("FAIL rstmid_no_resp: got %0d cycles of Resp_Valid required 0", seen_rv);
    end
    @(posedge Clk); #1;
    a0[0] = 16'($urandom); b0[0] = 16'($urandom);
    a1[0] = 16'($urandom); b1[0] = 16'($urandom);
    v0[0] = 1'b1; v1[0] = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({rdy0[0], rdy1[0]} !== 2'b10) begin
      n_bad++;
      $display("FAIL rstmid_prio rdy0,rdy1: got %b required 10", {rdy0[0], rdy1[0]});
    end
    @(posedge Clk); #1;
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
  endtask

  // Randomized traffic. The model keeps transaction timestamps: a handshake in
  // cycle T yields a response from cycle T+ADD_CYCLES+1 until it is taken, and
  // the block is idle again the cycle after it is taken.
  task automatic test_random(input int d, input int ncyc);
    bit          pend [2];
    logic [15:0] pa [2];
    logic [15:0] pb [2];
    bit          inflight;
    int          t_hs;
    bit          e_id;
    logic [16:0] e_res;
    bit          prio;
    bit          g0, g1, erv, w;
    int          nl;
    nl = lat(d);
    apply_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    inflight = 1'b0; prio = 1'b0; t_hs = 0; e_id = 1'b0; e_res = '0;
    for (int c = 0; c < ncyc; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          pa[r] = 16'($urandom);
          pb[r] = 16'($urandom);
          if ($urandom_range(0, 2) == 0) pend[r] = 1'b1;
        end
      end
      v0[d] = pend[0]; a0[d] = pa[0]; b0[d] = pb[0];
      v1[d] = pend[1]; a1[d] = pa[1]; b1[d] = pb[1];
      rr[d] = ($urandom_range(0, 3) != 0);
      @(negedge Clk);
      g0  = !inflight && pend[0] && (!pend[1] || !prio);
      g1  = !inflight && pend[1] && (!pend[0] ||  prio);
      erv = inflight && (cyc >= t_hs + nl + 1);
      n_cmp++;
      if ({rdy0[d], rdy1[d], rv[d], busy[d]} !== {g0, g1, erv, inflight}) begin
        n_bad++;
        $display("FAIL rand_d%0d_cyc%0d rdy0,rdy1,valid,busy: got %b required %b", d, cyc,
                 {rdy0[d], rdy1[d], rv[d], busy[d]}, {g0, g1, erv, inflight});
      end
      if (erv) begin
        n_cmp++;
        if ({rid[d], rsum[d], rco[d]} !== {e_id, e_res[15:0], e_res[16]}) begin
          n_bad++;
          $display("FAIL rand_d%0d_cyc%0d id,sum,co: got %h required %h", d, cyc,
                   {rid[d], rsum[d], rco[d]}, {e_id, e_res[15:0], e_res[16]});
        end
        if (rr[d]) inflight = 1'b0;
      end
      if (g0 || g1) begin
        w        = g1;
        inflight = 1'b1;
        t_hs     = cyc;
        e_id     = w;
        e_res    = {1'b0, pa[w]} + {1'b0, pb[w]};
        prio     = !w;
        pend[w]  = 1'b0;
      end
      @(posedge Clk); #1;
    end
    idle_inputs();
    repeat (8) @(posedge Clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_multicycle();
    test_reset_mid();
    test_random(0, 400);
    test_random(1, 400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
